bios_watchdog: RTL and testbench



---
 rtl/bios_wd_pkg.sv | 26 ++
 rtl/bios_watchdog_prescaler.sv | 30 +++
 rtl/bios_watchdog.sv | 146 ++++++++++++++
 tb/tb_bios_watchdog.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bios_wd_pkg.sv
// Shared types and constants for the BIOS boot watchdog.
package bios_wd_pkg;

  // Watchdog FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    EXPIRED = 3'd2,
    HALT    = 3'd3,
    DONE    = 3'd4
  } wd_state_e;

  // Default LPC address of the watchdog command register.
  localparam logic [7:0] WD_REG_ADDR_DEF = 8'h06;

  // Command register bit positions.
  localparam int CMD_KICK_BIT = 0;
  localparam int CMD_STOP_BIT = 1;

  // WdStatus bit positions: {GiveUp, Timeout, Armed, Done}.
  localparam int STAT_DONE    = 0;
  localparam int STAT_ARMED   = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_GIVEUP  = 3;

endpackage

// File: rtl/bios_watchdog_prescaler.sv
// Divides LpcClock down to the watchdog tick (one-cycle pulse per TICK_DIV cycles).
module wd_prescaler #(
  parameter int TICK_DIV = 33000
) (
  input  logic LpcClock,
  input  logic ResetN,
  input  logic En,
  input  logic Clr,
  output logic Tick
);

  localparam int             CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Free-running divider while enabled; Clr wins so a kick restarts the tick period.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      r_cnt <= '0;
    end else if (Clr) begin
      r_cnt <= '0;
    end else if (En) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign Tick = En & ~Clr & (r_cnt == LAST);

endmodule

// File: rtl/bios_watchdog.sv
// BIOS boot watchdog: arms on host reset release, expires after TIMEOUT_TICKS
// ticks unless kicked or stopped over LPC, and requests a flash swap on expiry.
//
// Handshake: there is no valid/ready flow. Write is a one-cycle strobe that is
// acted on only in ARMED; ForceSwap is a one-cycle registered pulse coinciding
// with the EXPIRED state and consumed unconditionally downstream.
module bios_watchdog
  import bios_wd_pkg::*;
#(
  parameter int          TICK_DIV      = 33000,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd60000,
  parameter int          MAX_SWAPS     = 2,
  parameter logic [7:0]  WD_REG_ADDR   = WD_REG_ADDR_DEF
) (
  input  logic       LpcClock,
  input  logic       ResetN,
  input  logic       MainReset,
  input  logic       SwapDisable,
  input  logic       Write,
  input  logic [7:0] RegAddress,
  input  logic [7:0] DataWr,
  output logic [1:0] ForceSwap,
  output logic [3:0] WdStatus,
  output logic [1:0] ExpCnt
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_SWAPS);

  wd_state_e   r_state;
  wd_state_e   w_next;
  logic        r_mrq;
  logic        r_arm;
  logic [15:0] r_ticks;
  logic [1:0]  r_exp_cnt;
  logic [1:0]  r_force;
  logic [1:0]  w_pulse;
  logic        w_wr_cmd;
  logic        w_stop;
  logic        w_kick;
  logic        w_in_armed;
  logic        w_kick_armed;
  logic        w_expire;
  logic        w_clr;
  logic        w_tick;
  logic        w_unused;

  assign w_wr_cmd     = Write & (RegAddress == WD_REG_ADDR);
  assign w_stop       = w_wr_cmd & DataWr[CMD_STOP_BIT];
  assign w_kick       = w_wr_cmd & DataWr[CMD_KICK_BIT] & ~DataWr[CMD_STOP_BIT];
  assign w_in_armed   = (r_state == ARMED);
  assign w_kick_armed = w_in_armed & MainReset & w_kick;
  assign w_expire     = w_in_armed & (r_ticks == TIMEOUT_TICKS);
  // Counters restart on a kick and whenever ARMED is not going to continue.
  assign w_clr        = ~w_in_armed | (w_next != ARMED) | w_kick_armed;
  assign w_unused     = ^DataWr[7:2];

  wd_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .LpcClock (LpcClock),
    .ResetN   (ResetN),
    .En       (w_in_armed),
    .Clr      (w_clr),
    .Tick     (w_tick)
  );

  // Host-run edge detector; the arm request is the registered rising-edge compare.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      r_mrq <= 1'b0;
      r_arm <= 1'b0;
    end else begin
      r_mrq <= MainReset;
      r_arm <= MainReset & ~r_mrq;
    end
  end

  // FSM state register.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; host reset overrides everything, then Stop > Kick > expiry.
  always_comb begin
    w_next = r_state;
    if (!MainReset) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (r_arm) w_next = ARMED;
        ARMED: begin
          if (w_stop)        w_next = DONE;
          else if (w_kick)   w_next = ARMED;
          else if (w_expire) w_next = EXPIRED;
        end
        EXPIRED: w_next = HALT;
        default: w_next = r_state;
      endcase
    end
  end

  // Swap request chosen on entry to EXPIRED so the registered pulse lines up with that state.
  always_comb begin
    w_pulse = 2'b00;
    if (w_in_armed && (w_next == EXPIRED) && (r_exp_cnt < MAX_CNT) && !SwapDisable) begin
      w_pulse = (r_exp_cnt == 2'd0) ? 2'b01 : 2'b10;
    end
  end

  // Tick counter saturates at the timeout value; the FSM leaves ARMED there anyway.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      r_ticks <= 16'd0;
    end else if (w_clr) begin
      r_ticks <= 16'd0;
    end else if (w_tick && (r_ticks != TIMEOUT_TICKS)) begin
      r_ticks <= r_ticks + 16'd1;
    end
  end

  // Consecutive expiry count: cleared by a successful boot, bumped once per expiry.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      r_exp_cnt <= 2'd0;
    end else if (w_in_armed && (w_next == DONE)) begin
      r_exp_cnt <= 2'd0;
    end else if ((r_state == EXPIRED) && MainReset && (r_exp_cnt < MAX_CNT)) begin
      r_exp_cnt <= r_exp_cnt + 2'd1;
    end
  end

  // Registered one-cycle swap pulse.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) r_force <= 2'b00;
    else         r_force <= w_pulse;
  end

  assign ForceSwap               = r_force;
  assign ExpCnt                  = r_exp_cnt;
  assign WdStatus[STAT_DONE]     = (r_state == DONE);
  assign WdStatus[STAT_ARMED]    = (r_state == ARMED);
  assign WdStatus[STAT_TIMEOUT]  = (r_state == HALT) || (r_state == EXPIRED);
  assign WdStatus[STAT_GIVEUP]   = (r_exp_cnt == MAX_CNT);

endmodule

// File: tb/tb_bios_watchdog.sv
// Self-checking bench for bios_watchdog with TICK_DIV=4, TIMEOUT_TICKS=5, MAX_SWAPS=2.
module tb_bios_watchdog;

  localparam int MAX = 2;
  localparam int LAT = 22;  // arm edge to pulse cycle: 4*5 + 2
  localparam int KLAT = 21; // kick edge to pulse cycle: 4*5 + 1

  logic       LpcClock = 1'b0;
  logic       ResetN;
  logic       MainReset;
  logic       SwapDisable;
  logic       Write;
  logic [7:0] RegAddress;
  logic [7:0] DataWr;
  logic [1:0] ForceSwap;
  logic [3:0] WdStatus;
  logic [1:0] ExpCnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = -1;
  int base  = 0;
  int m_cnt = 0;
  logic [33:0] exp_q[$];

  bios_watchdog #(
    .TICK_DIV      (4),
    .TIMEOUT_TICKS (16'd5),
    .MAX_SWAPS     (2),
    .WD_REG_ADDR   (8'h06)
  ) dut (
    .LpcClock    (LpcClock),
    .ResetN      (ResetN),
    .MainReset   (MainReset),
    .SwapDisable (SwapDisable),
    .Write       (Write),
    .RegAddress  (RegAddress),
    .DataWr      (DataWr),
    .ForceSwap   (ForceSwap),
    .WdStatus    (WdStatus),
    .ExpCnt      (ExpCnt)
  );

  // Clock
  always #5 LpcClock = ~LpcClock;

  // Advance one clock; at the falling edge retire any due or observed pulse against the scoreboard.
  task automatic step();
    logic [33:0] e;
    @(posedge LpcClock);
    cyc++;
    @(negedge LpcClock);
    if (ForceSwap !== 2'b00 || (exp_q.size() > 0 && int'(exp_q[0][33:2]) <= cyc)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pulse: cycle %0d ForceSwap=%b, expected none", cyc, ForceSwap);
      end else begin
        e = exp_q.pop_front();
        if (int'(e[33:2]) != cyc || ForceSwap !== e[1:0])
          begin
            n_err++;
            $display("FAIL pulse: cycle %0d ForceSwap=%b, expected %b at cycle %0d",
                     cyc, ForceSwap, e[1:0], int'(e[33:2]));
          end
      end
    end
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    Write = 1'b1; RegAddress = a; DataWr = d;
    step();
    Write = 1'b0; RegAddress = 8'h00; DataWr = 8'h00;
  endtask

  // Raise MainReset; the next rising edge is cycle 0 of this boot.
  task automatic arm();
    MainReset = 1'b1;
    base = cyc + 1;
  endtask

  task automatic drop_mr();
    MainReset = 1'b0;
    step(); step();
  endtask

  // Reference model of one expiry at cycle 'at'.
  task automatic expect_expiry(input int at);
    if (m_cnt < MAX && !SwapDisable)
      exp_q.push_back({32'(at), (m_cnt == 0) ? 2'b01 : 2'b10});
    if (m_cnt < MAX) m_cnt++;
  endtask

  task automatic apply_reset();
    MainReset = 1'b0;
    ResetN = 1'b0;
    step(); step();
    ResetN = 1'b1;
    step();
    m_cnt = 0;
  endtask

  task automatic test_reset();
    ResetN = 1'b0; MainReset = 1'b0; SwapDisable = 1'b0;
    Write = 1'b0; RegAddress = 8'h00; DataWr = 8'h00;
    repeat (3) step();
    n_vec++; if (ForceSwap !== 2'b00) begin n_err++; $display("FAIL reset_fs: got %b want 00", ForceSwap); end
    n_vec++; if (WdStatus !== 4'b0000) begin n_err++; $display("FAIL reset_status: got %b want 0000", WdStatus); end
    n_vec++; if (ExpCnt !== 2'd0) begin n_err++; $display("FAIL reset_expcnt: got %0d want 0", ExpCnt); end
    ResetN = 1'b1;
    step(); step();
    n_vec++; if (WdStatus !== 4'b0000) begin n_err++; $display("FAIL idle_status: got %b want 0000", WdStatus); end
  endtask

  // Three unkicked boots: swap[0], swap[1], then give up.
  task automatic test_expiry();
    for (int b = 0; b < 3; b++) begin
      arm();
      expect_expiry(base + LAT);
      run_until(base + 25);
      n_vec++; if (ExpCnt !== 2'(m_cnt)) begin n_err++; $display("FAIL expiry_cnt boot%0d: got %0d want %0d", b, ExpCnt, m_cnt); end
      n_vec++; if (WdStatus !== {m_cnt == MAX, 3'b100}) begin n_err++; $display("FAIL expiry_status boot%0d: got %b want %b", b, WdStatus, {m_cnt == MAX, 3'b100}); end
      drop_mr();
    end
  endtask

  task automatic test_kick();
    apply_reset();
    arm();
    run_until(base + 14);
    write_reg(8'h06, 8'h01);
    run_until(base + 20);
    write_reg(8'h04, 8'h01);  // wrong address: must not restart the count
    expect_expiry(base + 15 + KLAT);
    run_until(base + 40);
    n_vec++; if (WdStatus !== 4'b0100) begin n_err++; $display("FAIL kick_status: got %b want 0100", WdStatus); end
    n_vec++; if (ExpCnt !== 2'(m_cnt)) begin n_err++; $display("FAIL kick_cnt: got %0d want %0d", ExpCnt, m_cnt); end
    drop_mr();
  endtask

  task automatic test_stop();
    arm();
    run_until(base + 4);
    write_reg(8'h04, 8'h02);  // wrong address: ignored
    n_vec++; if (WdStatus !== 4'b0010) begin n_err++; $display("FAIL stop_wrong_addr: got %b want 0010", WdStatus); end
    run_until(base + 9);
    write_reg(8'h06, 8'h03);  // both bits: Stop wins
    m_cnt = 0;
    run_until(base + 12);
    n_vec++; if (WdStatus !== 4'b0001) begin n_err++; $display("FAIL stop_status: got %b want 0001", WdStatus); end
    n_vec++; if (ExpCnt !== 2'd0) begin n_err++; $display("FAIL stop_cnt: got %0d want 0", ExpCnt); end
    write_reg(8'h06, 8'h01);  // kick in DONE: ignored
    run_until(base + 30);
    n_vec++; if (WdStatus !== 4'b0001) begin n_err++; $display("FAIL done_hold: got %b want 0001", WdStatus); end
    drop_mr();
  endtask

  task automatic test_swap_disable();
    SwapDisable = 1'b1;
    arm();
    expect_expiry(base + LAT);
    run_until(base + 26);
    n_vec++; if (ExpCnt !== 2'(m_cnt)) begin n_err++; $display("FAIL swapdis_cnt: got %0d want %0d", ExpCnt, m_cnt); end
    n_vec++; if (WdStatus[2] !== 1'b1) begin n_err++; $display("FAIL swapdis_timeout: got %b want 1", WdStatus[2]); end
    SwapDisable = 1'b0;
    drop_mr();
  endtask

  task automatic test_abort_mainreset();
    arm();
    run_until(base + 20);
    MainReset = 1'b0;
    run_until(base + 30);
    n_vec++; if (ExpCnt !== 2'(m_cnt)) begin n_err++; $display("FAIL abort_mr_cnt: got %0d want %0d", ExpCnt, m_cnt); end
    n_vec++; if (WdStatus !== {m_cnt == MAX, 3'b000}) begin n_err++; $display("FAIL abort_mr_status: got %b want %b", WdStatus, {m_cnt == MAX, 3'b000}); end
  endtask

  // Random kick train; the last kick sets the expiry time. Gaps of 21 land on the expiry edge.
  task automatic test_back_to_back();
    int t;
    int nk;
    arm();
    t = base;
    nk = $urandom_range(1, 4);
    for (int k = 0; k < nk; k++) begin
      t = t + $urandom_range(2, 21);
      run_until(t - 1);
      write_reg(8'h06, 8'h01);
    end
    expect_expiry(t + KLAT);
    run_until(t + KLAT + 4);
    n_vec++; if (ExpCnt !== 2'(m_cnt)) begin n_err++; $display("FAIL b2b_cnt: got %0d want %0d", ExpCnt, m_cnt); end
    drop_mr();
  endtask

  task automatic test_abort_resetn();
    arm();
    run_until(base + 20);
    ResetN = 1'b0;
    MainReset = 1'b0;
    #1;
    m_cnt = 0;
    n_vec++; if (ForceSwap !== 2'b00) begin n_err++; $display("FAIL abort_rst_fs: got %b want 00", ForceSwap); end
    n_vec++; if (WdStatus !== 4'b0000) begin n_err++; $display("FAIL abort_rst_status: got %b want 0000", WdStatus); end
    n_vec++; if (ExpCnt !== 2'd0) begin n_err++; $display("FAIL abort_rst_cnt: got %0d want 0", ExpCnt); end
    run_until(base + 26);
    ResetN = 1'b1;
    run_until(base + 30);
    n_vec++; if (WdStatus !== 4'b0000) begin n_err++; $display("FAIL after_rst_status: got %b want 0000", WdStatus); end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_kick();
    test_stop();
    test_swap_disable();
    test_abort_mainreset();
    test_back_to_back();
    test_abort_resetn();
    repeat (5) step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d pulses outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
